// File: rtl/addsub_nibble_seq_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub sequencer.
// master drives operands and accepts results; slave is the sequencer.
interface addsub_nibble_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output in_valid, op_sub, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_sub, op_a, op_b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Multi-precision add/sub sequencer driving an external 4-bit slice, LSB first.
// Define ADDSUB_SEQ_OVF_EN to add signed-overflow detection.
module addsub_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_nibble_seq_if.slave  io,
  output logic [3:0]          fa_a,
  output logic [3:0]          fa_b,
  output logic                fa_cin,
  input  logic [3:0]          fa_sum,
  input  logic                fa_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic          sub_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  a_sh, b_sh;
  logic          accept;
  logic          last;

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    fa_a         = 4'h0;
    fa_b         = 4'h0;
    fa_cin       = 1'b0;
    last         = 1'b0;
    unique case (state_q)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_d = RUN;
      end
      RUN: begin
        fa_a   = a_sh[3:0];
        fa_cin = carry_q;
        // slice re-inverts B when cin=1; net effect is B^sub
        fa_b   = b_sh[3:0] ^ {4{sub_q ^ carry_q}};
        last   = (idx_q == LAST);
        if (last) state_d = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = io.in_ready && io.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      io.result    <= '0;
      io.carry_out <= 1'b0;
    end else if (accept) begin
      a_q     <= io.op_a;
      b_q     <= io.op_b;
      sub_q   <= io.op_sub;
      idx_q   <= '0;
      carry_q <= io.op_sub;
    end else if (state_q == RUN) begin
      io.result[{idx_q, 2'b00} +: 4] <= fa_sum;
      carry_q <= fa_cout;
      idx_q   <= idx_q + 1'b1;
      if (last) io.carry_out <= fa_cout;
    end
  end

`ifdef ADDSUB_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
               (fa_sum[3] != a_q[W-1]);
    end
  end

  assign io.overflow = ovf_q;
`else
  assign io.overflow = 1'b0;
`endif

endmodule
